// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with the
// trial subtraction built as a carry-in-1 adder (A + ~B + 1).
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The partial remainder always stays below the divisor, so its top bit
    // is never set between steps; only the shifted value needs WIDTH+1 bits.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   gen_bit;
    logic [WIDTH:0]   prop_bit;
    logic [WIDTH+1:0] carry;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;

    assign r_shift  = {r_q, q_q[WIDTH-1]};
    assign sub_b    = ~{1'b0, d_q};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_carry
            assign gen_bit[gi]   = r_shift[gi] & sub_b[gi];
            assign prop_bit[gi]  = r_shift[gi] ^ sub_b[gi];
            assign carry[gi + 1] = gen_bit[gi] | (prop_bit[gi] & carry[gi]);
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign trial[gi] = prop_bit[gi] ^ carry[gi];
        end
    endgenerate

    // Carry out of the top bit means R' >= D: keep the difference.
    assign no_borrow = carry[WIDTH+1];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                r_d   = no_borrow ? trial : r_shift[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
                // Results load on the edge into DONE so they coincide with done.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: expected results are queued when a
// start is driven and compared when done is observed.
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           a;
        int           b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives start for one cycle (asserted at a negedge, sampled at the next
    // posedge) and queues the expected result from a plain arithmetic model.
    task automatic issue(input int a, input int b);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        e.a = a;
        e.b = b;
        e.z = (b == 0);
        e.q = (b == 0) ? {W{1'b1}} : W'(a / b);
        e.r = (b == 0) ? W'(a) : W'(a % b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Returns the number of cycles after the start cycle at which done was seen,
    // or 0 if it never appeared within the budget.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        issue(13, 3);
        e = sb.pop_front();
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== {n <= 5, n == 5}) begin
                errors++;
                $display("FAIL basic_handshake cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                         n, busy, done, n <= 5, n == 5);
            end
            if (n == 5) begin
                checks++;
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    errors++;
                    $display("FAIL basic_result 13/3: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                             quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
                $display("div %0d/%0d -> q=%0d r=%0d z=%b", e.a, e.b, quotient, remainder, div_by_zero);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL basic_hold: busy=%b done=%b q=%0d r=%0d z=%b, required idle with q=%0d r=%0d",
                     busy, done, quotient, remainder, div_by_zero, e.q, e.r);
        end
    endtask

    task automatic test_vectors();
        int   tbl_a[4] = '{15, 5, 0, 15};
        int   tbl_b[4] = '{1, 7, 9, 15};
        int   lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(tbl_a[i], tbl_b[i]);
            wait_done(lat);
            e = sb.pop_front();
            checks++;
            if (lat != 5 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++;
                $display("FAIL vector %0d/%0d: lat=%0d q=%0d r=%0d z=%b, required lat=5 q=%0d r=%0d z=%b",
                         e.a, e.b, lat, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
            $display("div %0d/%0d -> q=%0d r=%0d z=%b lat=%0d", e.a, e.b, quotient, remainder, div_by_zero, lat);
        end
    endtask

    task automatic test_div_zero();
        int   lat;
        exp_t e;
        issue(9, 0);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL div_zero 9/0: lat=%0d q=%0d r=%0d z=%b, required lat=1 q=%0d r=%0d z=%b",
                     lat, quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        $display("div 9/0 -> q=%0d r=%0d z=%b lat=%0d", quotient, remainder, div_by_zero, lat);
        issue(8, 2);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 5 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL after_zero 8/2: lat=%0d q=%0d r=%0d z=%b, required lat=5 q=%0d r=%0d z=0",
                     lat, quotient, remainder, div_by_zero, e.q, e.r);
        end
        $display("div 8/2 -> q=%0d r=%0d z=%b lat=%0d", quotient, remainder, div_by_zero, lat);
    endtask

    task automatic test_ignore_start();
        int   pulses = 0;
        int   first = 0;
        exp_t e;
        issue(14, 3);
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(2);
        divisor  = W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        e = sb.pop_front();
        for (int n = 3; n <= 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    checks++;
                    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                        errors++;
                        $display("FAIL ignore_start_result: q=%0d r=%0d z=%b, required q=%0d r=%0d z=0",
                                 quotient, remainder, div_by_zero, e.q, e.r);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1 || first != 5) begin
            errors++;
            $display("FAIL ignore_start_pulses: pulses=%0d at cycle %0d, required 1 at cycle 5", pulses, first);
        end
        $display("div 14/3 (start 2/2 ignored) -> q=%0d r=%0d pulses=%0d", quotient, remainder, pulses);
    endtask

    task automatic test_reset_in_flight();
        int   seen = 0;
        int   lat;
        exp_t e;
        issue(12, 5);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_in_flight: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abandon: %0d cycles with busy/done, required 0", seen);
        end
        issue(12, 5);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 5 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL after_reset 12/5: lat=%0d q=%0d r=%0d z=%b, required lat=5 q=%0d r=%0d z=0",
                     lat, quotient, remainder, div_by_zero, e.q, e.r);
        end
        $display("div 12/5 after reset -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    endtask

    task automatic test_sweep();
        int   lat;
        int   recon;
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b);
                wait_done(lat);
                e = sb.pop_front();
                checks++;
                if (lat != ((b == 0) ? 1 : 5) || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    errors++;
                    $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                             a, b, lat, quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
                if (b != 0) begin
                    recon = int'(quotient) * b + int'(remainder);
                    checks++;
                    if (recon != a || int'(remainder) >= b) begin
                        errors++;
                        $display("FAIL invariant %0d/%0d: q*d+r=%0d r=%0d, required %0d with r<%0d",
                                 a, b, recon, remainder, a, b);
                    end
                end
                $display("div %0d/%0d -> q=%0d r=%0d z=%b lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_ignore_start();
        test_reset_in_flight();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
